tlul_dev_responder: RTL and testbench

Device-side TL-UL endpoint that sits on one crossbar device port (GPIO, LDO, DCDC, PLL, TSEN, DAP, …) and turns accepted A-channel requests into single-cycle register-bus accesses. It returns D-channel responses through a small response FIFO. It checks each request against its slot's base/mask in the xbar address map and rejects illegal accesses locally. Peripherals use it to avoid hand-rolling TL-UL handshakes.

---
 rtl/tlul_dev_responder.sv | 184 ++++++++++++++++++
 tb/tb_tlul_dev_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_dev_responder.sv
// rtl/tlul_dev_responder.sv - TL-UL device endpoint turning A requests into register-bus strobes (optional TLUL_DEV_RSP_ERR_CHECK_EN)
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [3:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_dev_responder
    import tlul_pkg::*;
#(
    parameter logic [31:0] AddrSpace = 32'h40080000,
    parameter logic [31:0] AddrMask  = 32'h0000ffff,
    parameter int unsigned AW        = 16,
    parameter int unsigned RspDepth  = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  tl_h2d_t       tl_i,
    output tl_d2h_t       tl_o,
    output logic          reg_req_o,
    output logic          reg_we_o,
    output logic [AW-1:0] reg_addr_o,
    output logic [31:0]   reg_wdata_o,
    output logic [3:0]    reg_be_o,
    input  logic [31:0]   reg_rdata_i,
    input  logic          reg_error_i
);

    localparam int unsigned CW = $clog2(RspDepth + 1);
    localparam int unsigned PW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    // Only the fields that cannot be rebuilt at pop time are buffered.
    typedef struct packed {
        logic        is_data;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_t;

    rsp_t          mem [RspDepth];
    rsp_t          push_entry;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          a_ready;
    logic          d_valid;
    logic          accept;
    logic          pop;
    logic          is_get;
    logic          legal;
    logic          rsp_error;
    logic          unused_tl;

    assign a_ready = (count != CW'(RspDepth));
    assign d_valid = (count != '0);
    assign accept  = tl_i.a_valid & a_ready;
    assign pop     = d_valid & tl_i.d_ready;
    assign is_get  = (tl_i.a_opcode == Get);

`ifdef TLUL_DEV_RSP_ERR_CHECK_EN
    logic addr_ok;
    logic opc_ok;
    logic size_ok;
    logic align_ok;
    logic mask_ok;

    // Local legality screen: anything failing it is answered here, never forwarded.
    always_comb begin
        addr_ok  = ((tl_i.a_address & ~AddrMask) == AddrSpace);
        opc_ok   = is_get || (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
        size_ok  = (tl_i.a_size <= 2'd2);
        case (tl_i.a_size)
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = ~tl_i.a_address[0];
            default: align_ok = (tl_i.a_address[1:0] == 2'b00);
        endcase
        mask_ok  = !((tl_i.a_opcode == PutFullData) && (tl_i.a_size == 2'd2) && (tl_i.a_mask != 4'hf));
        legal    = addr_ok & opc_ok & size_ok & align_ok & mask_ok;
    end

    assign unused_tl = ^{tl_i.a_param};
`else
    assign legal     = 1'b1;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:AW], AddrSpace, AddrMask};
`endif

    // Register-bus decode, live only while a request is actually being accepted.
    always_comb begin
        reg_req_o   = accept & legal;
        reg_we_o    = accept & ~is_get;
        reg_addr_o  = accept ? tl_i.a_address[AW-1:0] : '0;
        reg_wdata_o = accept ? tl_i.a_data : '0;
        reg_be_o    = accept ? tl_i.a_mask : '0;
    end

    // Response built in the accept cycle, since backend data is only valid then.
    always_comb begin
        rsp_error          = legal ? reg_error_i : 1'b1;
        push_entry.is_data = is_get;
        push_entry.size    = tl_i.a_size;
        push_entry.source  = tl_i.a_source;
        push_entry.error   = rsp_error;
        if (!is_get) begin
            push_entry.data = 32'h0;
        end else if (rsp_error) begin
            push_entry.data = 32'hffffffff;
        end else begin
            push_entry.data = reg_rdata_i;
        end
    end

    // Response storage; contents are don't-care while not counted as valid.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Occupancy and circular pointers; reset discards every buffered response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PW'(RspDepth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(RspDepth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end
        end
    end

    // D channel shows the head entry, zeroed when nothing is pending.
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        tl_o.d_valid = d_valid;
        if (d_valid) begin
            tl_o.d_opcode = mem[rd_ptr].is_data ? AccessAckData : AccessAck;
            tl_o.d_size   = mem[rd_ptr].size;
            tl_o.d_source = mem[rd_ptr].source;
            tl_o.d_data   = mem[rd_ptr].data;
            tl_o.d_error  = mem[rd_ptr].error;
        end
    end

endmodule

// File: tb/tb_tlul_dev_responder.sv
// tb/tb_tlul_dev_responder.sv - randomized scoreboard bench for tlul_dev_responder
module tb_tlul_dev_responder;
    import tlul_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [15:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_be_o;
    logic [31:0] reg_rdata_i = 32'h0;
    logic        reg_error_i = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit [2:0]  op;
        bit [1:0]  size;
        bit [7:0]  src;
        bit [31:0] data;
        bit        err;
    } exp_t;

    exp_t q[$];

    tlul_dev_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .tl_i        (tl_i),
        .tl_o        (tl_o),
        .reg_req_o   (reg_req_o),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_be_o    (reg_be_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit model_legal(input tl_h2d_t t);
`ifdef TLUL_DEV_RSP_ERR_CHECK_EN
        int unsigned bytes;
        bytes = 1 << t.a_size;
        if ((t.a_address & ~32'h0000ffff) != 32'h40080000) return 0;
        if (!(t.a_opcode inside {3'd0, 3'd1, 3'd4})) return 0;
        if (t.a_size > 2) return 0;
        if ((t.a_address % bytes) != 0) return 0;
        if (t.a_opcode == 3'd0 && t.a_size == 2 && t.a_mask != 4'hf) return 0;
        return 1;
`else
        return (t.a_valid | ~t.a_valid);
`endif
    endfunction

    // Per-cycle compare against the queue model, then advance the model by one clock.
    always @(negedge clk) begin
        if (!rst_ni) begin
            q.delete();
            chk("rst_a_ready", tl_o.a_ready, 1);
            chk("rst_d_valid", tl_o.d_valid, 0);
            chk("rst_d_fields", {tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_error}, 0);
            chk("rst_d_data", tl_o.d_data, 0);
            chk("rst_reg", {reg_req_o, reg_we_o}, 0);
        end else begin
            bit   rdy;
            bit   acc;
            bit   lg;
            bit   had;
            exp_t e;
            rdy = (q.size() != DEPTH);
            had = (q.size() != 0);
            acc = tl_i.a_valid && rdy;
            lg  = model_legal(tl_i);
            chk("a_ready", tl_o.a_ready, rdy);
            chk("d_valid", tl_o.d_valid, had);
            chk("d_zero_fields", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 0);
            if (had) begin
                chk("d_opcode", tl_o.d_opcode, q[0].op);
                chk("d_size", tl_o.d_size, q[0].size);
                chk("d_source", tl_o.d_source, q[0].src);
                chk("d_data", tl_o.d_data, q[0].data);
                chk("d_error", tl_o.d_error, q[0].err);
            end
            chk("reg_req", reg_req_o, acc && lg);
            chk("reg_we", reg_we_o, acc && tl_i.a_opcode != 3'd4);
            chk("reg_addr", reg_addr_o, acc ? tl_i.a_address[15:0] : 0);
            chk("reg_wdata", reg_wdata_o, acc ? tl_i.a_data : 0);
            chk("reg_be", reg_be_o, acc ? tl_i.a_mask : 0);
            if (had && tl_i.d_ready) void'(q.pop_front());
            if (acc) begin
                e.op   = (tl_i.a_opcode == 3'd4) ? 3'd1 : 3'd0;
                e.size = tl_i.a_size;
                e.src  = tl_i.a_source;
                e.err  = lg ? reg_error_i : 1'b1;
                e.data = (tl_i.a_opcode != 3'd4) ? 32'h0 : (e.err ? 32'hffffffff : reg_rdata_i);
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                       input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_size    = size;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
        tl_i.a_param   = 3'd0;
    endtask

    task automatic idle(input int n);
        tl_i.a_valid = 1'b0;
        tl_i.d_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit done;
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("init_a_ready", tl_o.a_ready, 1);
        chk("init_d_valid", tl_o.d_valid, 0);
        rst_ni = 1'b1;
        step();

        // Single Get returning backend data
        reg_rdata_i = 32'hdeadbeef;
        reg_error_i = 1'b0;
        req(3'd4, 32'h40080010, 2'd2, 4'hf, 32'h0, 8'h5a);
        @(negedge clk);
        chk("get_req", reg_req_o, 1);
        chk("get_addr", reg_addr_o, 16'h0010);
        chk("get_we", reg_we_o, 0);
        step();
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("get_d_valid", tl_o.d_valid, 1);
        chk("get_d_opcode", tl_o.d_opcode, 1);
        chk("get_d_data", tl_o.d_data, 32'hdeadbeef);
        chk("get_d_error", tl_o.d_error, 0);
        chk("get_d_source", tl_o.d_source, 8'h5a);
        step();

        // PutPartialData
        req(3'd1, 32'h40080004, 2'd2, 4'b0011, 32'h12345678, 8'h21);
        @(negedge clk);
        chk("put_we", reg_we_o, 1);
        chk("put_be", reg_be_o, 4'b0011);
        chk("put_wdata", reg_wdata_o, 32'h12345678);
        step();
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("put_d_opcode", tl_o.d_opcode, 0);
        chk("put_d_data", tl_o.d_data, 0);
        idle(2);

        // Backpressure fills the FIFO; held request waits for a pop
        tl_i.d_ready = 1'b0;
        req(3'd4, 32'h40080020, 2'd2, 4'hf, 32'h0, 8'd10);
        step();
        req(3'd4, 32'h40080024, 2'd2, 4'hf, 32'h0, 8'd11);
        step();
        req(3'd4, 32'h40080028, 2'd2, 4'hf, 32'h0, 8'd12);
        @(negedge clk);
        chk("full_a_ready", tl_o.a_ready, 0);
        chk("full_no_req", reg_req_o, 0);
        step();
        step();
        tl_i.d_ready = 1'b1;
        @(negedge clk);
        chk("no_passthru", tl_o.a_ready, 0);
        chk("bp_first_src", tl_o.d_source, 8'd10);
        step();
        @(negedge clk);
        chk("held_accept", reg_req_o, 1);
        chk("bp_second_src", tl_o.d_source, 8'd11);
        step();
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("bp_third_src", tl_o.d_source, 8'd12);
        idle(2);

        // Eight back-to-back requests
        for (int i = 0; i < 8; i++) begin
            req(3'd4, 32'h40080000 + 32'(i * 4), 2'd2, 4'hf, 32'h0, 8'(i));
            @(negedge clk);
            if (i > 0) begin
                chk("stream_valid", tl_o.d_valid, 1);
                chk("stream_src", tl_o.d_source, 8'(i - 1));
            end
            step();
        end
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_src", tl_o.d_source, 8'd7);
        idle(2);

        // Out-of-window Get
        reg_rdata_i = 32'hcafef00d;
        req(3'd4, 32'h40090000, 2'd2, 4'hf, 32'h0, 8'h33);
        @(negedge clk);
`ifdef TLUL_DEV_RSP_ERR_CHECK_EN
        chk("oow_no_req", reg_req_o, 0);
        step();
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("oow_d_error", tl_o.d_error, 1);
        chk("oow_d_data", tl_o.d_data, 32'hffffffff);
        step();
        req(3'd4, 32'h40080000, 2'd3, 4'hf, 32'h0, 8'h34);
        step();
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("size3_d_error", tl_o.d_error, 1);
`else
        chk("oow_req", reg_req_o, 1);
        step();
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        chk("oow_d_error", tl_o.d_error, 0);
        chk("oow_d_data", tl_o.d_data, 32'hcafef00d);
`endif
        idle(2);

        // Reset with two responses buffered
        tl_i.d_ready = 1'b0;
        req(3'd4, 32'h40080040, 2'd2, 4'hf, 32'h0, 8'h41);
        step();
        req(3'd4, 32'h40080044, 2'd2, 4'hf, 32'h0, 8'h42);
        step();
        tl_i.a_valid = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_d_valid", tl_o.d_valid, 0);
        chk("arst_a_ready", tl_o.a_ready, 1);
        step();
        rst_ni = 1'b1;
        tl_i.d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", tl_o.d_valid, 0);
            step();
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [2:0]  op;
            logic [31:0] addr;
            case ($urandom % 4)
                0:       op = 3'd4;
                1:       op = 3'd0;
                2:       op = 3'd1;
                default: op = 3'($urandom);
            endcase
            if ($urandom % 8 != 0) begin
                addr = 32'h40080000 | ($urandom & 32'h0000ffff);
                if ($urandom % 4 != 0) addr[1:0] = 2'b00;
            end else begin
                addr = $urandom;
            end
            req(op, addr, ($urandom % 8 < 6) ? 2'd2 : 2'($urandom),
                ($urandom % 4 != 0) ? 4'hf : 4'($urandom), $urandom, 8'($urandom));
            tl_i.a_param = 3'($urandom);
            tl_i.a_valid = ($urandom % 3 != 0);
            tl_i.d_ready = ($urandom % 4 != 0);
            reg_rdata_i  = $urandom;
            reg_error_i  = ($urandom % 8 == 0);
            step();
        end
        done = 1'b0;
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
